// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and its load-extension datapath.
//   - FSM state encoding (IDLE / REQ / DONE)
//   - funct3 access codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - access-size decode, byte-enable, lane-offset and misalignment helpers
// No ports (package).
// ---------------------------------------------------------------------------
package lsu_pkg;

  // FSM state encoding.
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_REQ  = 2'd1;
  localparam lsu_state_t S_DONE = 2'd2;

  // funct3 access codes from the decoder.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Reserved funct3 codes (011, 110, 111) fall through to a word access.
  function automatic access_size_t access_size(input logic [2:0] f3);
    access_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      F3_W:        sz = SZ_WORD;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Byte lane actually addressed: halves only look at addr[1], words start
  // at lane 0 regardless of the low address bits.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [1:0] lane;
    case (access_size(f3))
      SZ_BYTE: lane = off;
      SZ_HALF: lane = {off[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [3:0] be;
    case (access_size(f3))
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [1:0] off);
    logic mis;
    case (access_size(f3))
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational lane select plus sign/zero extension of a 32-bit read word.
// Shared with the forwarding path, so it holds no state.
// Ports:
//   funct3  in  3   access size and signedness (funct3[2] = 1 -> zero-extend)
//   offset  in  2   byte address bits [1:0] of the access
//   word    in  32  raw bus read word
//   result  out 32  extended load data
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    lane    = lane_offset(funct3, offset);
    shifted = word >> {lane, 3'b000};
    case (access_size(funct3))
      SZ_BYTE: result = funct3[2] ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = funct3[2] ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Runs one data-memory bus transaction per memory instruction using a
// req/ack handshake, stalls the core while the access is in flight and
// returns extended load data for writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses skip the bus and pulse misalign instead.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   mreq, mem_write   decoder: memory access / store select
//   funct3            access size and sign
//   addr, wdata       byte address and store data (rs2)
//   stall             holds PC and pipeline registers
//   rdata/rdata_valid registered load data and its one-cycle valid pulse
//   misalign          one-cycle pulse on a trapped misaligned access
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   bus request side
//   bus_ack, bus_rdata                             bus response side
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mreq,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_t        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              err_q;
  logic              access_err;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] load_word;

  // Replicate narrow store data across all lanes so the byte enables alone
  // decide which bytes memory keeps.
  always_comb begin
    case (access_size(funct3))
      SZ_BYTE: store_word = {4{wdata[7:0]}};
      SZ_HALF: store_word = {2{wdata[15:0]}};
      default: store_word = wdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign access_err = misaligned(funct3, addr[1:0]);
`else
  assign access_err = 1'b0;
`endif

  // Extension works on the registered access attributes and the live bus
  // word, so the result is ready to capture in the ack cycle.
  load_extend u_load_extend (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (bus_rdata),
    .result (load_word)
  );

  // Transaction FSM; bus outputs are registered at acceptance and stay
  // frozen for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      err_q     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mreq) begin
            we_q      <= mem_write;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            err_q     <= access_err;
            bus_we    <= mem_write;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= byte_enable(funct3, addr[1:0]);
            bus_wdata <= store_word;
            state     <= access_err ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            if (!we_q) begin
              rdata <= load_word;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // mreq here still belongs to the retiring instruction.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so reset removes the request immediately.
  assign bus_req     = (state == S_REQ);
  assign stall       = !rst && (((state == S_IDLE) && mreq) || (state == S_REQ));
  assign rdata_valid = (state == S_DONE) && !we_q && !err_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (state == S_DONE) && err_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Randomised scoreboard bench for load_store_unit. The stimulus thread
// predicts each bus transaction and each load/trap result from the access
// rules and queues them; a bus responder and a result monitor pop and
// compare independently.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mreq        (mreq),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          delay;
  } bus_exp_t;

  typedef struct {
    bit          is_mis;
    logic [31:0] value;
  } res_exp_t;

  bus_exp_t    bus_q[$];
  res_exp_t    res_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] model_rdata  = 32'h0;
  bit          stray_ack    = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model (access rules as plain arithmetic) ----
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int eff_offset(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_bytes(f3);
    int lo = int'(a % 4);
    if (sz == 1) return lo;
    if (sz == 2) return (lo >= 2) ? 2 : 0;
    return 0;
  endfunction

  function automatic bit traps(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz = size_bytes(f3);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
`else
    return (f3 === 3'bxxx) && (a === 32'hx);
`endif
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int m = ((1 << size_bytes(f3)) - 1) << eff_offset(f3, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = size_bytes(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    int sz = size_bytes(f3);
    longint unsigned full = 64'd1 << (8 * sz);
    longint unsigned v = ({32'h0, word} >> (8 * eff_offset(f3, a))) % full;
    if (f3[2] == 1'b0 && sz < 4 && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  // Issue one instruction (or a bubble), queue its predicted behaviour and
  // hold it until the core would retire it; checks the stall length.
  task automatic applyStimulus(input bit req, input bit we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rword, input int delay);
    bus_exp_t be_e;
    res_exp_t re;
    int exp_stall;
    int stalls;
    int cycles;
    logic st;
    exp_stall = 0;
    if (req) begin
      if (traps(f3, a)) begin
        re.is_mis = 1'b1;
        re.value  = 32'h0;
        res_q.push_back(re);
        exp_stall = 1;
      end else begin
        be_e.addr  = a & 32'hFFFF_FFFC;
        be_e.be    = ref_be(f3, a);
        be_e.we    = we;
        be_e.wdata = ref_wdata(f3, wd);
        be_e.rword = rword;
        be_e.delay = delay;
        bus_q.push_back(be_e);
        if (!we) begin
          re.is_mis = 1'b0;
          re.value  = ref_load(f3, a, rword);
          res_q.push_back(re);
        end
        exp_stall = 2 + delay;
      end
    end
    mreq      = req;
    mem_write = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    stalls = 0;
    cycles = 0;
    do begin
      @(negedge clk);
      st = stall;
      if (st) stalls++;
      @(posedge clk);
      #1;
      cycles++;
    end while (st && cycles < 60);
    if (cycles >= 60) checkOutput("instr_timeout", stall, 1'b0);
    checkOutput("stall_cycles", stalls, exp_stall);
  endtask

  // ---------------- bus responder + bus-side checker ----------------------
  initial begin : bus_model
    bit          active;
    int          wc;
    bus_exp_t    cur;
    logic [31:0] snap_addr;
    logic [36:0] snap_ctl;
    active    = 1'b0;
    wc        = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst || !bus_req) begin
        active    = 1'b0;
        bus_ack   = !rst && stray_ack;
        bus_rdata = $urandom;
      end else begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            checkOutput("unexpected_bus_req", bus_req, 1'b0);
            cur.delay = 0;
            cur.rword = $urandom;
          end else begin
            cur = bus_q.pop_front();
            checkOutput("bus_addr", bus_addr, cur.addr);
            checkOutput("bus_be", bus_be, cur.be);
            checkOutput("bus_we", bus_we, cur.we);
            if (cur.we) checkOutput("bus_wdata", bus_wdata, cur.wdata);
          end
          snap_addr = bus_addr;
          snap_ctl  = {bus_be, bus_we, bus_wdata};
          active    = 1'b1;
          wc        = 0;
        end else begin
          checkOutput("bus_addr_stable", bus_addr, snap_addr);
          checkOutput("bus_ctl_stable", {bus_be, bus_we, bus_wdata}, snap_ctl);
        end
        if (wc >= cur.delay) begin
          bus_ack   = 1'b1;
          bus_rdata = cur.rword;
          active    = 1'b0;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
          wc++;
        end
      end
    end
  end

  // ---------------- result monitor ----------------------------------------
  initial begin : result_monitor
    res_exp_t re;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_rdata = 32'h0;
      end else if (rdata_valid || misalign) begin
        if (res_q.size() == 0) begin
          checkOutput("unexpected_pulse", {rdata_valid, misalign}, 2'b00);
        end else begin
          re = res_q.pop_front();
          if (re.is_mis) begin
            checkOutput("misalign_pulse", {misalign, rdata_valid}, 2'b10);
            checkOutput("rdata_hold_trap", rdata, model_rdata);
          end else begin
            checkOutput("load_pulse", {rdata_valid, misalign}, 2'b10);
            checkOutput("rdata", rdata, re.value);
            model_rdata = re.value;
          end
        end
      end else begin
        checkOutput("rdata_hold", rdata, model_rdata);
      end
    end
  end

  // ---------------- main stimulus -----------------------------------------
  initial begin : main
    bus_exp_t    abort_e;
    logic [2:0]  f3;
    int          dly;
    rst       = 1'b1;
    mreq      = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    #1;
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_bus_req", bus_req, 1'b0);
    checkOutput("reset_bus_we", bus_we, 1'b0);
    checkOutput("reset_bus_addr", bus_addr, 32'h0);
    checkOutput("reset_bus_be", bus_be, 4'h0);
    checkOutput("reset_bus_wdata", bus_wdata, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_rdata_valid", rdata_valid, 1'b0);
    checkOutput("reset_misalign", misalign, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases from the access rules.
    applyStimulus(1'b1, 1'b1, T_W,  32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    applyStimulus(1'b1, 1'b1, T_B,  32'h103, 32'h0000_00A5, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, T_B,  32'h102, 32'h0, 32'h0080_0000, 0);
    applyStimulus(1'b1, 1'b0, T_BU, 32'h102, 32'h0, 32'h0080_0000, 2);
    applyStimulus(1'b1, 1'b0, T_H,  32'h100, 32'h0, 32'h1234_F00D, 3);
    applyStimulus(1'b1, 1'b0, T_W,  32'h101, 32'h0, 32'hCAFE_BABE, 0);
    applyStimulus(1'b0, 1'b0, T_W,  32'h0,   32'h0, 32'h0, 0);

    // Reset in the middle of a REQ phase; the queued bus cycle never acks.
    abort_e.addr  = 32'h200;
    abort_e.be    = 4'hF;
    abort_e.we    = 1'b0;
    abort_e.wdata = 32'h0;
    abort_e.rword = 32'h5555_AAAA;
    abort_e.delay = 1000;
    bus_q.push_back(abort_e);
    mreq      = 1'b1;
    mem_write = 1'b0;
    funct3    = T_W;
    addr      = 32'h200;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bus_req_before_reset", bus_req, 1'b1);
    #2;
    rst  = 1'b1;
    mreq = 1'b0;
    #1;
    checkOutput("bus_req_async_drop", bus_req, 1'b0);
    checkOutput("stall_in_reset", stall, 1'b0);
    checkOutput("rdata_in_reset", rdata, 32'h0);
    checkOutput("bus_be_in_reset", bus_be, 4'h0);
    @(negedge clk);
    #1;
    rst       = 1'b0;
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_after_stray_ack", {rdata_valid, bus_req, stall}, 3'b000);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, T_H, 32'h302, 32'h0, 32'h8001_7FFF, 1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      f3  = 3'($urandom_range(0, 7));
      dly = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), f3,
                    $urandom, $urandom, $urandom, dly);
    end
    mreq = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    checkOutput("result_queue_drained", res_q.size(), 0);
    checkOutput("bus_queue_drained", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
